pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter word_size, default 32, giving the width of the PC, offset and target datapaths.
REQ-002 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-003 SHALL provide clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL provide branch_taken, input, 1, the branch decision from the branch-compare logic; 1 means the branch condition is met.
REQ-006 SHALL provide branch_valid, input, 1, qualifying branch_taken as a resolved conditional branch this cycle.
REQ-007 SHALL provide jump, input, 1, an unconditional jump request.
REQ-008 SHALL provide imm_offset, input, word_size, the signed branch offset in words.
REQ-009 SHALL provide jump_target, input, word_size, the absolute jump byte address.
REQ-010 SHALL provide instr_done, input, 1, a pulse from the main controller marking the end of instruction execution.
REQ-011 SHALL provide mem_ready, input, 1, the instruction-memory fetch acknowledge.
REQ-012 SHALL provide fetch_req, output, 1, the instruction fetch request.
REQ-013 SHALL provide pc, output, word_size, the current program counter, also used as the fetch address.
REQ-014 SHALL provide pc_write, output, 1, a one-cycle pulse on each PC update.
REQ-015 SHALL provide taken_count, output, 16, the count of redirects (taken branches plus jumps).
REQ-016 SHALL provide misalign_err, output, 1, a sticky flag set by a non-word-aligned next PC.

Function
REQ-017 SHALL implement the states FETCH, WAIT_MEM, EXEC, UPDATE and HALT.
REQ-018 FETCH SHALL assert fetch_req and go to WAIT_MEM next cycle.
REQ-019 WAIT_MEM SHALL hold fetch_req=1 and pc stable until mem_ready=1, then latch pc_plus4=pc+4 (mod 2^word_size) and go to EXEC.
REQ-020 EXEC SHALL wait for instr_done=1; on that cycle it SHALL compute next_pc and go to UPDATE.
REQ-021 next_pc SHALL be jump_target when jump=1, regardless of branch_valid.
REQ-022 next_pc SHALL be pc_plus4 + (imm_offset<<2) when jump=0, branch_valid=1 and branch_taken=1, with wrap modulo 2^word_size and the offset sign-extended.
REQ-023 next_pc SHALL be pc_plus4 in all other cases; branch_taken without branch_valid SHALL be ignored.
REQ-024 If next_pc[1:0]!=0, the block SHALL go to HALT instead of UPDATE, set misalign_err=1, and leave pc unchanged.
REQ-025 UPDATE SHALL load pc<=next_pc, pulse pc_write=1 for exactly one cycle, and go to FETCH.
REQ-026 taken_count SHALL increment in UPDATE when the redirect was a jump or a taken branch, and saturate at 16'hFFFF.
REQ-027 HALT SHALL be terminal until reset: fetch_req=0, pc_write=0, and all inputs ignored.
REQ-028 instr_done outside EXEC and mem_ready outside WAIT_MEM SHALL be ignored.
REQ-029 Minimum instruction period SHALL be 4 cycles (FETCH, WAIT_MEM with mem_ready=1, EXEC with instr_done=1, UPDATE).

Reset
REQ-030 With rst_n=0 at a rising edge, the block SHALL set state=FETCH, pc=RESET_VECTOR, pc_plus4=0, taken_count=0, misalign_err=0, fetch_req=0, pc_write=0.
REQ-031 Reset SHALL take effect from any state, including mid-fetch and HALT; the first fetch_req=1 SHALL appear in the cycle after rst_n returns high.

Verification
REQ-032 Sequential: reset, mem_ready=1, instr_done each EXEC, no branch/jump for 3 instructions -> pc 0,4,8,12; pc_write pulses every 4 cycles; taken_count=0.
REQ-033 Taken branch: pc=0x10, branch_valid=1, branch_taken=1, imm_offset=-2 -> pc=0x0C, taken_count=1; repeated with branch_taken=0 -> pc=0x14, count unchanged.
REQ-034 Priority and qualifier: jump=1 with jump_target=0x100, branch_valid=1, branch_taken=1, imm_offset=5 -> pc=0x100; separately branch_taken=1, branch_valid=0 -> pc=pc+4.
REQ-035 Misalign and wrap: jump_target=0x102 -> HALT, misalign_err=1, pc held, fetch_req=0 until reset; pc=0xFFFFFFFC, no branch -> pc=0x00000000.
REQ-036 Stall and reset: mem_ready low for 5 cycles -> fetch_req held high, pc stable, instr_done pulses ignored; rst_n=0 asserted in WAIT_MEM -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch/branch/jump bundle between the main controller and the PC sequencer.
// The controller drives the decisions; the sequencer returns PC and status.
interface pc_sequencer_if #(
    parameter int word_size = 32
);
    logic                 branch_taken;
    logic                 branch_valid;
    logic                 jump;
    logic [word_size-1:0] imm_offset;
    logic [word_size-1:0] jump_target;
    logic                 instr_done;
    logic                 mem_ready;
    logic                 fetch_req;
    logic [word_size-1:0] pc;
    logic                 pc_write;
    logic [15:0]          taken_count;
    logic                 misalign_err;

    modport master (
        output branch_taken, branch_valid, jump,
        output imm_offset, jump_target,
        output instr_done, mem_ready,
        input  fetch_req, pc, pc_write,
        input  taken_count, misalign_err
    );

    modport slave (
        input  branch_taken, branch_valid, jump,
        input  imm_offset, jump_target,
        input  instr_done, mem_ready,
        output fetch_req, pc, pc_write,
        output taken_count, misalign_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch, wait, execute, update loop with
// branch/jump redirect, redirect counter and a terminal misalign halt.
module pc_sequencer #(
    parameter int                   word_size    = 32,
    parameter logic [word_size-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        FETCH,
        WAIT_MEM,
        EXEC,
        UPDATE,
        HALT
    } state_e;

    state_e               state_q, state_d;
    logic [word_size-1:0] pc_q, pc_d;
    logic [word_size-1:0] pc_plus4_q, pc_plus4_d;
    logic [word_size-1:0] next_pc_q, next_pc_d;
    logic                 redirect_q, redirect_d;
    logic [15:0]          count_q, count_d;
    logic                 misalign_q, misalign_d;
    logic                 run_q;

    logic [word_size-1:0] br_target;
    logic [word_size-1:0] target;
    logic                 redirect;

    // Same-width add wraps mod 2^word_size; the shift keeps the offset's sign.
    assign br_target = pc_plus4_q + (bus.imm_offset << 2);

    always_comb begin
        target   = pc_plus4_q;
        redirect = 1'b0;
        if (bus.jump) begin
            target   = bus.jump_target;
            redirect = 1'b1;
        end else if (bus.branch_valid && bus.branch_taken) begin
            target   = br_target;
            redirect = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_plus4_d    = pc_plus4_q;
        next_pc_d     = next_pc_q;
        redirect_d    = redirect_q;
        count_d       = count_q;
        misalign_d    = misalign_q;
        bus.fetch_req = 1'b0;
        bus.pc_write  = 1'b0;
        unique case (state_q)
            FETCH: begin
                // run_q holds off the first fetch until one cycle after reset.
                bus.fetch_req = run_q;
                if (run_q) state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                bus.fetch_req = 1'b1;
                if (bus.mem_ready) begin
                    pc_plus4_d = pc_q + word_size'(4);
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (bus.instr_done) begin
                    next_pc_d  = target;
                    redirect_d = redirect;
                    if (target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        state_d = UPDATE;
                    end
                end
            end
            UPDATE: begin
                bus.pc_write = 1'b1;
                pc_d         = next_pc_q;
                if (redirect_q && count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_VECTOR;
            pc_plus4_q <= '0;
            next_pc_q  <= '0;
            redirect_q <= 1'b0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            next_pc_q  <= next_pc_d;
            redirect_q <= redirect_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            run_q      <= 1'b1;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.taken_count  = count_q;
    assign bus.misalign_err = misalign_q;
endmodule
